// File: rtl/sbp_lookup_ctrl.sv
`default_nettype none
// sbp_lookup_ctrl (rev 1.0): admits lookups into the stage chain, tracks in-flight slots,
// queues tail results in a FWFT FIFO and drains the chain before each stage-memory write.
module sbp_lookup_ctrl #(
   parameter int STAGE_BITS    = 6,
   parameter int LOCATION_BITS = 11,
   parameter int ADDR_BITS     = 11,
   parameter int DATA_BITS     = 64,
   parameter int NUM_STAGES    = 8,
   parameter int STAGE_LATENCY = 2,
   parameter int FIFO_DEPTH    = 16
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                in_valid,
   output logic                                in_ready,
   input  logic [31:0]                         in_ip_addr,
   output logic                                pl_valid_o,
   output logic [31:0]                         pl_ip_addr_o,
   output logic [STAGE_BITS-1:0]               pl_stage_id_o,
   output logic [LOCATION_BITS-1:0]            pl_location_o,
   output logic [5:0]                          pl_bit_pos_o,
   output logic [LOCATION_BITS+STAGE_BITS-1:0] pl_result_o,
   input  logic [31:0]                         pl_ip_addr_i,
   input  logic [LOCATION_BITS+STAGE_BITS-1:0] pl_result_i,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [31:0]                         out_ip_addr,
   output logic [LOCATION_BITS+STAGE_BITS-1:0] out_result,
   input  logic                                upd_valid,
   output logic                                upd_ready,
   input  logic [STAGE_BITS-1:0]               upd_stage,
   input  logic [ADDR_BITS-1:0]                upd_addr,
   input  logic [DATA_BITS-1:0]                upd_data,
   output logic                                wr_en,
   output logic [STAGE_BITS-1:0]               wr_stage,
   output logic [ADDR_BITS-1:0]                wr_addr,
   output logic [DATA_BITS-1:0]                wr_data
);

   localparam int L  = NUM_STAGES * STAGE_LATENCY;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = 32 + LOCATION_BITS + STAGE_BITS;
   localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEPTH);

   localparam logic [1:0] S_RUN   = 2'd0;
   localparam logic [1:0] S_DRAIN = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;

   logic [1:0]            state_q, state_d;
   logic                  alive_q, skip_q;
   logic                  pl_valid_q;
   logic [31:0]           pl_ip_q;
   logic [STAGE_BITS-1:0] pl_stage_q;
   logic [L-1:0]          dl_q;
   logic [CW-1:0]         credit_q, credit_d;
   logic [CW-1:0]         count_q;
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [EW-1:0]         mem_q [FIFO_DEPTH];
   logic                  wr_en_q;
   logic [STAGE_BITS-1:0] wr_stage_q;
   logic [ADDR_BITS-1:0]  wr_addr_q;
   logic [DATA_BITS-1:0]  wr_data_q;
   logic                  issue, drained, push, pop;

   assign issue = in_valid && in_ready;
   // The tail slot is being pushed this cycle, so it no longer counts as in flight.
   assign drained = !pl_valid_q && (dl_q[L-2:0] == '0);
   assign push = dl_q[L-1];
   assign pop = out_valid && out_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_RUN;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RUN:   if (upd_valid && !skip_q) state_d = drained ? S_WRITE : S_DRAIN;
         S_DRAIN: if (drained) state_d = S_WRITE;
         S_WRITE: state_d = S_RUN;
         default: state_d = S_RUN;
      endcase
   end

   always_comb begin
      in_ready  = 1'b0;
      upd_ready = 1'b0;
      if (state_q == S_RUN)
         in_ready = alive_q && (skip_q || !upd_valid) && (credit_q < CREDIT_MAX);
      if (state_q == S_WRITE)
         upd_ready = 1'b1;
   end

   always_comb begin
      credit_d = credit_q;
      case ({issue, pop})
         2'b10:   credit_d = credit_q + CW'(1);
         2'b01:   credit_d = credit_q - CW'(1);
         default: credit_d = credit_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alive_q    <= 1'b0;
         skip_q     <= 1'b0;
         pl_valid_q <= 1'b0;
         pl_ip_q    <= '0;
         pl_stage_q <= '0;
         dl_q       <= '0;
         credit_q   <= '0;
         wr_en_q    <= 1'b0;
         wr_stage_q <= '0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         alive_q    <= 1'b1;
         skip_q     <= (state_q == S_WRITE);
         pl_valid_q <= issue;
         pl_ip_q    <= issue ? in_ip_addr : '0;
         pl_stage_q <= issue ? STAGE_BITS'(1) : '0;
         dl_q       <= {dl_q[L-2:0], pl_valid_q};
         credit_q   <= credit_d;
         wr_en_q    <= (state_d == S_WRITE);
         wr_stage_q <= (state_d == S_WRITE) ? upd_stage : '0;
         wr_addr_q  <= (state_d == S_WRITE) ? upd_addr  : '0;
         wr_data_q  <= (state_d == S_WRITE) ? upd_data  : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= {pl_ip_addr_i, pl_result_i};
   end

   assign out_valid = (count_q != '0);
   assign {out_ip_addr, out_result} = out_valid ? mem_q[rd_ptr_q] : '0;

   assign pl_valid_o    = pl_valid_q;
   assign pl_ip_addr_o  = pl_ip_q;
   assign pl_stage_id_o = pl_stage_q;
   assign pl_location_o = '0;
   assign pl_bit_pos_o  = '0;
   assign pl_result_o   = '0;

   assign wr_en    = wr_en_q;
   assign wr_stage = wr_stage_q;
   assign wr_addr  = wr_addr_q;
   assign wr_data  = wr_data_q;

endmodule
`default_nettype wire
